input_router_vc: RTL and testbench

- Parametrised successor to the single-table NoC input router.
- Sits on one router input port. Decodes head flits with XY or YX dimension-order routing and keeps an open route per virtual channel, so body/tail flits follow their head.
- Presents each accepted flit with a one-hot output-port request through a registered valid/ready stage.
- Adds a per-VC route lifecycle (open on head, close on tail), protocol-error detection and a saturating error counter.

---
 rtl/input_router_vc.sv | 180 ++++++++++++++++++
 tb/tb_input_router_vc.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/input_router_vc.sv
// Input-port router for one NoC port: XY/YX route decode on head flits, per-VC open
// routes for body/tail flits, protocol-error detection and a one-deep registered output.
module input_router_vc #(
    parameter int FLIT_WIDTH  = 37,
    parameter int NUM_VC      = 3,
    parameter int X_WIDTH     = 2,
    parameter int Y_WIDTH     = 2,
    parameter int ROUTER_X    = 0,
    parameter int ROUTER_Y    = 0,
    parameter int ROUTING_ALG = 0,
    parameter int ERR_CNT_W   = 8,
    localparam int VC_W       = (NUM_VC > 1) ? $clog2(NUM_VC) : 1
) (
    input  logic                  clk,
    input  logic                  arst,
    input  logic                  flit_valid_i,
    output logic                  flit_ready_o,
    input  logic [FLIT_WIDTH-1:0] flit_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [FLIT_WIDTH-1:0] flit_o,
    output logic [VC_W-1:0]       vc_o,
    output logic [4:0]            router_port_o,
    output logic                  err_o,
    output logic [ERR_CNT_W-1:0]  err_cnt_o
);

    typedef enum logic [1:0] {
        FT_HEAD      = 2'd0,
        FT_BODY      = 2'd1,
        FT_TAIL      = 2'd2,
        FT_HEAD_TAIL = 2'd3
    } flit_type_e;

    localparam logic [4:0] PORT_N = 5'b00001;
    localparam logic [4:0] PORT_S = 5'b00010;
    localparam logic [4:0] PORT_W = 5'b00100;
    localparam logic [4:0] PORT_E = 5'b01000;
    localparam logic [4:0] PORT_L = 5'b10000;

    localparam int X_LSB = FLIT_WIDTH - 2 - X_WIDTH;
    localparam int Y_LSB = X_LSB - Y_WIDTH;
    localparam logic [X_WIDTH-1:0] RX       = X_WIDTH'(ROUTER_X);
    localparam logic [Y_WIDTH-1:0] RY       = Y_WIDTH'(ROUTER_Y);
    localparam logic [VC_W:0]      NUM_VC_L = (VC_W+1)'(NUM_VC);

    // Dimension-order route: the first dimension with a non-zero offset wins, else Local.
    function automatic logic [4:0] compute_route(input logic [X_WIDTH-1:0] x,
                                                 input logic [Y_WIDTH-1:0] y);
        logic [4:0] x_port;
        logic [4:0] y_port;
        logic [4:0] first_port;
        logic [4:0] second_port;
        x_port = (x > RX) ? PORT_E : ((x < RX) ? PORT_W : 5'b00000);
        y_port = (y > RY) ? PORT_S : ((y < RY) ? PORT_N : 5'b00000);
        if (ROUTING_ALG == 0) begin
            first_port  = x_port;
            second_port = y_port;
        end else begin
            first_port  = y_port;
            second_port = x_port;
        end
        if (first_port != 5'b00000) begin
            return first_port;
        end else if (second_port != 5'b00000) begin
            return second_port;
        end else begin
            return PORT_L;
        end
    endfunction

    flit_type_e          type_s;
    logic [X_WIDTH-1:0]  x_s;
    logic [Y_WIDTH-1:0]  y_s;
    logic [VC_W-1:0]     vc_s;
    logic                vc_ok_s;
    logic                accept_s;
    logic [4:0]          route_s;
    logic                open_cur_s;
    logic [4:0]          port_cur_s;
    logic                fwd_s;
    logic                err_s;
    logic [4:0]          port_sel_s;

    logic [NUM_VC-1:0]   open_r;
    logic [4:0]          port_r [NUM_VC];

    assign type_s       = flit_type_e'(flit_i[FLIT_WIDTH-1 -: 2]);
    assign x_s          = flit_i[X_LSB +: X_WIDTH];
    assign y_s          = flit_i[Y_LSB +: Y_WIDTH];
    assign vc_s         = flit_i[VC_W-1:0];
    assign vc_ok_s      = ({1'b0, vc_s} < NUM_VC_L);
    assign flit_ready_o = ~out_valid_o | out_ready_i;
    assign accept_s     = flit_valid_i & flit_ready_o;
    assign route_s      = compute_route(x_s, y_s);
    assign open_cur_s   = vc_ok_s ? open_r[vc_s] : 1'b0;
    assign port_cur_s   = vc_ok_s ? port_r[vc_s] : 5'b00000;

    // Classify the incoming flit: forward or drop, error or not, and which port it goes to.
    always_comb begin
        fwd_s      = 1'b0;
        err_s      = 1'b0;
        port_sel_s = 5'b00000;
        if (!vc_ok_s) begin
            err_s = 1'b1;
        end else begin
            case (type_s)
                FT_HEAD, FT_HEAD_TAIL: begin
                    fwd_s      = 1'b1;
                    err_s      = open_cur_s;
                    port_sel_s = route_s;
                end
                FT_BODY, FT_TAIL: begin
                    fwd_s      = open_cur_s;
                    err_s      = ~open_cur_s;
                    port_sel_s = port_cur_s;
                end
                default: begin
                    err_s = 1'b1;
                end
            endcase
        end
    end

    // Per-VC route table: heads open/overwrite, a tail on an open route closes it.
    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            open_r <= '0;
            for (int v = 0; v < NUM_VC; v++) begin
                port_r[v] <= 5'b00000;
            end
        end else if (accept_s && vc_ok_s) begin
            case (type_s)
                FT_HEAD: begin
                    open_r[vc_s] <= 1'b1;
                    port_r[vc_s] <= route_s;
                end
                FT_TAIL: begin
                    if (open_cur_s) begin
                        open_r[vc_s] <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Output stage: load on a forwarded accept, hold under backpressure, empty on a pop.
    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            out_valid_o   <= 1'b0;
            flit_o        <= '0;
            vc_o          <= '0;
            router_port_o <= 5'b00000;
        end else if (accept_s && fwd_s) begin
            out_valid_o   <= 1'b1;
            flit_o        <= flit_i;
            vc_o          <= vc_s;
            router_port_o <= port_sel_s;
        end else if (out_ready_i) begin
            out_valid_o   <= 1'b0;
            router_port_o <= 5'b00000;
        end
    end

    // Error pulse and saturating error count.
    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            err_o     <= 1'b0;
            err_cnt_o <= '0;
        end else begin
            err_o <= accept_s & err_s;
            if (accept_s && err_s && (err_cnt_o != {ERR_CNT_W{1'b1}})) begin
                err_cnt_o <= err_cnt_o + ERR_CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_input_router_vc.sv
// Self-checking bench for input_router_vc: an XY and a YX instance share the stimulus
// and are compared every cycle against a packet-level reference model.
module tb_input_router_vc;

    localparam int FW = 37;
    localparam int NV = 3;
    localparam int VW = 2;
    localparam int RX = 1;
    localparam int RY = 1;

    localparam logic [1:0] HEAD = 2'd0;
    localparam logic [1:0] BODY = 2'd1;
    localparam logic [1:0] TAIL = 2'd2;
    localparam logic [1:0] HT   = 2'd3;

    logic          clk = 1'b0;
    logic          arst = 1'b0;
    logic          flit_valid = 1'b0;
    logic          out_ready = 1'b1;
    logic [FW-1:0] flit = '0;

    logic          rdy [2];
    logic          ov  [2];
    logic          err [2];
    logic [FW-1:0] fo  [2];
    logic [VW-1:0] vco [2];
    logic [4:0]    po  [2];
    logic [7:0]    cnt [2];

    always #5 clk = ~clk;

    input_router_vc #(.FLIT_WIDTH(FW), .NUM_VC(NV), .X_WIDTH(2), .Y_WIDTH(2),
                      .ROUTER_X(RX), .ROUTER_Y(RY), .ROUTING_ALG(0), .ERR_CNT_W(8)) dut_xy (
        .clk(clk), .arst(arst), .flit_valid_i(flit_valid), .flit_ready_o(rdy[0]),
        .flit_i(flit), .out_valid_o(ov[0]), .out_ready_i(out_ready), .flit_o(fo[0]),
        .vc_o(vco[0]), .router_port_o(po[0]), .err_o(err[0]), .err_cnt_o(cnt[0]));

    input_router_vc #(.FLIT_WIDTH(FW), .NUM_VC(NV), .X_WIDTH(2), .Y_WIDTH(2),
                      .ROUTER_X(RX), .ROUTER_Y(RY), .ROUTING_ALG(1), .ERR_CNT_W(8)) dut_yx (
        .clk(clk), .arst(arst), .flit_valid_i(flit_valid), .flit_ready_o(rdy[1]),
        .flit_i(flit), .out_valid_o(ov[1]), .out_ready_i(out_ready), .flit_o(fo[1]),
        .vc_o(vco[1]), .router_port_o(po[1]), .err_o(err[1]), .err_cnt_o(cnt[1]));

    // Reference model state, index 0 = XY instance, 1 = YX instance.
    bit            m_open  [2][NV];
    logic [4:0]    m_rport [2][NV];
    bit            m_valid [2];
    logic [FW-1:0] m_flit  [2];
    logic [VW-1:0] m_vc    [2];
    logic [4:0]    m_port  [2];
    bit            m_err   [2];
    int            m_cnt   [2];
    string         nm      [2] = '{"xy", "yx"};

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [4:0] route(input int alg, input int x, input int y);
        int dx = x - RX;
        int dy = y - RY;
        logic [4:0] px = (dx > 0) ? 5'b01000 : ((dx < 0) ? 5'b00100 : 5'b00000);
        logic [4:0] py = (dy > 0) ? 5'b00010 : ((dy < 0) ? 5'b00001 : 5'b00000);
        logic [4:0] first  = (alg == 0) ? px : py;
        logic [4:0] second = (alg == 0) ? py : px;
        if (first != 5'b00000) return first;
        if (second != 5'b00000) return second;
        return 5'b10000;
    endfunction

    function automatic logic [FW-1:0] mk(input logic [1:0] t, input logic [1:0] x,
                                         input logic [1:0] y, input logic [1:0] vc,
                                         input int tag);
        logic [FW-1:0] r;
        r        = '0;
        r[36:35] = t;
        r[34:33] = x;
        r[32:31] = y;
        r[30:2]  = 29'(tag * 7 + 1);
        r[1:0]   = vc;
        return r;
    endfunction

    task automatic model_reset();
        for (int a = 0; a < 2; a++) begin
            for (int v = 0; v < NV; v++) begin
                m_open[a][v]  = 1'b0;
                m_rport[a][v] = 5'b00000;
            end
            m_valid[a] = 1'b0;
            m_flit[a]  = '0;
            m_vc[a]    = '0;
            m_port[a]  = 5'b00000;
            m_err[a]   = 1'b0;
            m_cnt[a]   = 0;
        end
    endtask

    task automatic model_step(input bit v, input logic [FW-1:0] f, input bit r);
        int t  = int'(f[36:35]);
        int x  = int'(f[34:33]);
        int y  = int'(f[32:31]);
        int vc = int'(f[1:0]);
        for (int a = 0; a < 2; a++) begin
            bit         acc = v && (!m_valid[a] || r);
            bit         fwd = 1'b0;
            bit         e   = 1'b0;
            logic [4:0] p   = 5'b00000;
            if (acc) begin
                if (vc >= NV) begin
                    e = 1'b1;
                end else if (t == 0 || t == 3) begin
                    fwd = 1'b1;
                    p   = route(a, x, y);
                    e   = m_open[a][vc];
                    if (t == 0) begin
                        m_open[a][vc]  = 1'b1;
                        m_rport[a][vc] = p;
                    end
                end else if (m_open[a][vc]) begin
                    fwd = 1'b1;
                    p   = m_rport[a][vc];
                    if (t == 2) m_open[a][vc] = 1'b0;
                end else begin
                    e = 1'b1;
                end
            end
            if (fwd) begin
                m_valid[a] = 1'b1;
                m_flit[a]  = f;
                m_vc[a]    = VW'(vc);
                m_port[a]  = p;
            end else if (r) begin
                m_valid[a] = 1'b0;
                m_port[a]  = 5'b00000;
            end
            m_err[a] = e;
            if (e && m_cnt[a] < 255) m_cnt[a]++;
        end
    endtask

    task automatic check_outputs();
        for (int a = 0; a < 2; a++) begin
            chk({nm[a], "_ready"}, 64'(rdy[a]), 64'(!m_valid[a] || out_ready));
            chk({nm[a], "_valid"}, 64'(ov[a]), 64'(m_valid[a]));
            chk({nm[a], "_port"},  64'(po[a]), 64'(m_port[a]));
            chk({nm[a], "_err"},   64'(err[a]), 64'(m_err[a]));
            chk({nm[a], "_cnt"},   64'(cnt[a]), 64'(m_cnt[a]));
            if (m_valid[a]) begin
                chk({nm[a], "_flit"}, 64'(fo[a]), 64'(m_flit[a]));
                chk({nm[a], "_vc"},   64'(vco[a]), 64'(m_vc[a]));
            end
        end
    endtask

    // One cycle: drive inputs, compare mid-cycle, advance the model, land 1 after the edge.
    task automatic step(input bit v, input logic [FW-1:0] f, input bit r);
        flit_valid = v;
        flit       = f;
        out_ready  = r;
        @(negedge clk);
        check_outputs();
        model_step(v, f, r);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        flit_valid = 1'b0;
        arst       = 1'b0;
        model_reset();
        @(negedge clk);
        arst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    logic [FW-1:0] h;
    logic [FW-1:0] b;
    logic [FW-1:0] rf;

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_valid", 64'(ov[0]), 64'(0));
        chk("reset_cnt", 64'(cnt[0]), 64'(0));
        do_reset();

        // XY: East packet, then body on the now-closed VC
        step(1'b1, mk(HEAD, 2'd3, 2'd0, 2'd0, 1), 1'b1);
        chk("xy_head_valid", 64'(ov[0]), 64'(1));
        chk("xy_head_east", 64'(po[0]), 64'(5'b01000));
        step(1'b1, mk(BODY, 2'd0, 2'd0, 2'd0, 2), 1'b1);
        chk("xy_body_east", 64'(po[0]), 64'(5'b01000));
        step(1'b1, mk(TAIL, 2'd0, 2'd0, 2'd0, 3), 1'b1);
        chk("xy_tail_east", 64'(po[0]), 64'(5'b01000));
        step(1'b1, mk(BODY, 2'd0, 2'd0, 2'd0, 4), 1'b1);
        chk("closed_body_err", 64'(err[0]), 64'(1));
        chk("closed_body_drop", 64'(ov[0]), 64'(0));

        // YX: North head, HEAD_TAIL Local on the open VC leaves the route intact
        step(1'b1, mk(HEAD, 2'd3, 2'd0, 2'd1, 5), 1'b1);
        chk("yx_head_north", 64'(po[1]), 64'(5'b00001));
        step(1'b1, mk(HT, 2'd1, 2'd1, 2'd1, 6), 1'b1);
        chk("yx_ht_local", 64'(po[1]), 64'(5'b10000));
        chk("yx_ht_open_err", 64'(err[1]), 64'(1));
        step(1'b1, mk(BODY, 2'd0, 2'd0, 2'd1, 7), 1'b1);
        chk("yx_body_north", 64'(po[1]), 64'(5'b00001));
        step(1'b1, mk(TAIL, 2'd0, 2'd0, 2'd1, 8), 1'b1);

        // Interleaved VCs
        step(1'b1, mk(HEAD, 2'd0, 2'd1, 2'd0, 9), 1'b1);
        chk("il_vc0_west", 64'(po[0]), 64'(5'b00100));
        step(1'b1, mk(HEAD, 2'd1, 2'd2, 2'd1, 10), 1'b1);
        chk("il_vc1_south", 64'(po[0]), 64'(5'b00010));
        step(1'b1, mk(BODY, 2'd0, 2'd0, 2'd0, 11), 1'b1);
        chk("il_vc0_body", 64'(po[0]), 64'(5'b00100));
        step(1'b1, mk(BODY, 2'd0, 2'd0, 2'd1, 12), 1'b1);
        chk("il_vc1_body", 64'(po[0]), 64'(5'b00010));
        step(1'b1, mk(TAIL, 2'd0, 2'd0, 2'd0, 13), 1'b1);
        step(1'b1, mk(TAIL, 2'd0, 2'd0, 2'd1, 14), 1'b1);

        // Backpressure: output holds, input stalls, then drains one per cycle
        h = mk(HEAD, 2'd3, 2'd3, 2'd2, 15);
        b = mk(BODY, 2'd0, 2'd0, 2'd2, 16);
        step(1'b1, h, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, b, 1'b0);
            chk("hold_valid", 64'(ov[0]), 64'(1));
            chk("hold_flit", 64'(fo[0]), 64'(h));
            chk("hold_port", 64'(po[0]), 64'(5'b01000));
            chk("hold_ready", 64'(rdy[0]), 64'(0));
        end
        step(1'b1, b, 1'b1);
        chk("release_flit", 64'(fo[0]), 64'(b));
        step(1'b1, mk(TAIL, 2'd0, 2'd0, 2'd2, 17), 1'b1);
        step(1'b0, '0, 1'b1);
        chk("drain_empty", 64'(ov[0]), 64'(0));

        // Error counter: first error, then saturation
        do_reset();
        step(1'b1, mk(BODY, 2'd0, 2'd0, 2'd2, 18), 1'b1);
        chk("err_first_pulse", 64'(err[0]), 64'(1));
        chk("err_first_cnt", 64'(cnt[0]), 64'(1));
        chk("err_first_drop", 64'(ov[0]), 64'(0));
        for (int i = 1; i < 300; i++) step(1'b1, mk(BODY, 2'd0, 2'd0, 2'd2, i), 1'b1);
        chk("err_sat_xy", 64'(cnt[0]), 64'(255));
        chk("err_sat_yx", 64'(cnt[1]), 64'(255));

        // Asynchronous reset mid-packet
        step(1'b1, mk(HEAD, 2'd3, 2'd0, 2'd0, 19), 1'b1);
        arst = 1'b0;
        #1;
        chk("arst_valid", 64'(ov[0]), 64'(0));
        chk("arst_port", 64'(po[0]), 64'(0));
        chk("arst_flit", 64'(fo[0]), 64'(0));
        chk("arst_cnt", 64'(cnt[0]), 64'(0));
        model_reset();
        flit_valid = 1'b0;
        @(negedge clk);
        arst = 1'b1;
        @(posedge clk);
        #1;
        step(1'b1, mk(BODY, 2'd0, 2'd0, 2'd0, 20), 1'b1);
        chk("post_rst_body_drop", 64'(ov[0]), 64'(0));
        chk("post_rst_body_cnt", 64'(cnt[0]), 64'(1));

        // Randomized traffic with random backpressure; the model checks every cycle
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            rf[31:0]  = $urandom();
            rf[36:32] = 5'($urandom());
            if ($urandom_range(3) == 0) rf[36:35] = HEAD;
            step($urandom_range(3) != 0, rf, $urandom_range(9) < 7);
        end
        step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
